// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment digit scanner with per-slot blanking and frame-synchronous value commit.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV      = 50_000,
    parameter int BLANK_CYC     = 500,
    parameter bit ACTIVE_LOW_AN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [3:0]                    nibble_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d, pend_buf_q, pend_buf_d;
    logic                  pend_q, pend_d, en_bit_q, en_bit_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  xfer, to_pend, slot_end, last_digit, to_idle, blank_entry;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        xfer        = data_valid & ~pend_q;
        slot_end    = state_q == DRIVE && cnt_q == CW'(SCAN_DIV - 1);
        last_digit  = idx_q == IW'(NUM_DIGITS - 1);
        to_idle     = state_q != IDLE && !enable;
        frame_done  = slot_end && last_digit && enable;
        to_pend     = xfer && state_q != IDLE && !to_idle;
        state_d     = !enable ? IDLE :
                      state_q == IDLE ? BLANK :
                      (state_q == BLANK && cnt_q == CW'(BLANK_CYC - 1)) ? DRIVE :
                      slot_end ? BLANK : state_q;
        cnt_d       = (state_d == IDLE || state_q == IDLE || cnt_q == CW'(SCAN_DIV - 1)) ? '0 : cnt_q + CW'(1);
        idx_d       = state_d == IDLE ? '0 : slot_end ? (last_digit ? '0 : idx_q + IW'(1)) : idx_q;
        // Pending data is folded into the shadow at a frame boundary or when the scan stops.
        shadow_d    = (pend_q && (frame_done || to_idle)) ? pend_buf_q :
                      (xfer && (state_q == IDLE || to_idle)) ? data_in : shadow_q;
        pend_d      = to_pend ? 1'b1 : (frame_done || to_idle) ? 1'b0 : pend_q;
        pend_buf_d  = to_pend ? data_in : pend_buf_q;
        blank_entry = state_d == BLANK && state_q != BLANK;
        nibble_d    = blank_entry ? shadow_d[4*idx_d +: 4] : nibble_q;
        en_bit_d    = blank_entry ? digit_en[idx_d] : en_bit_q;
        onehot      = NUM_DIGITS'(1) << idx_q;
        an          = (state_q == DRIVE && en_bit_q) ? (ACTIVE_LOW_AN ? ~onehot : onehot) : {NUM_DIGITS{ACTIVE_LOW_AN}};
        data_ready  = ~pend_q;
        nibble_out  = nibble_q;
        digit_idx   = idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            pend_buf_q <= '0;
            pend_q     <= 1'b0;
            en_bit_q   <= 1'b0;
            nibble_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pend_buf_q <= pend_buf_d;
            pend_q     <= pend_d;
            en_bit_q   <= en_bit_d;
            nibble_q   <= nibble_d;
        end
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the multi-digit 7-segment display. It holds a shadow copy of the displayed hex value and steps through the digits, one fixed slot per digit. Each slot has a short blanking interval to prevent ghosting. New display values are accepted over a valid/ready handshake and committed only on a frame boundary. A downstream hex-to-segment decoder consumes nibble_out.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (>=2)
SCAN_DIV, 50_000, clk cycles per digit slot (blank + drive)
BLANK_CYC, 500, leading cycles of each slot with all anodes off; 1 <= BLANK_CYC < SCAN_DIV
ACTIVE_LOW_AN, 1, 1: anode on = 0; 0: anode on = 1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  scan run; low forces IDLE
data_in  in  4*NUM_DIGITS  hex value, digit 0 = bits [3:0]
data_valid  in  1  data_in offered
data_ready  out  1  controller can accept data_in
digit_en  in  NUM_DIGITS  per-digit display mask, sampled at slot start
an  out  NUM_DIGITS  anode drive, one-hot when active, polarity per ACTIVE_LOW_AN
nibble_out  out  4  hex nibble of current digit
digit_idx  out  $clog2(NUM_DIGITS)  current digit index
frame_done  out  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (async, immediate): state IDLE; an all off (all 1s if ACTIVE_LOW_AN, else all 0s); nibble_out 0; digit_idx 0; frame_done 0; data_ready 1; shadow, pending buffer and slot counter 0; pending flag 0.
- Slot counter cnt, width $clog2(SCAN_DIV), counts 0..SCAN_DIV-1 and wraps. The slot period is exactly SCAN_DIV cycles.
- States: IDLE, BLANK, DRIVE.
- IDLE: an off, cnt 0, digit_idx 0. If enable=1, go to BLANK on the next edge with cnt=0.
- BLANK: an off for cnt 0..BLANK_CYC-1.
  - At BLANK entry, nibble_out <= shadow[4*idx +: 4] and the digit_en[idx] bit is latched.
  - When cnt==BLANK_CYC-1, go to DRIVE.
- DRIVE: for cnt BLANK_CYC..SCAN_DIV-1, an asserts only bit idx, and only if the latched enable bit is 1; otherwise an stays off. Slot timing is unchanged either way.
- End of DRIVE (cnt==SCAN_DIV-1): return to BLANK.
  - If idx==NUM_DIGITS-1: idx wraps to 0, frame_done=1 for that one cycle, and the frame commit occurs.
  - Otherwise idx increments by 1.
- Handshake:
  - A transfer occurs on a cycle with data_valid & data_ready.
  - Outside IDLE: data_in goes to the pending buffer, pending is set, and data_ready is 0 from the next cycle.
  - In IDLE: data_in is written directly to shadow and data_ready stays 1.
- Frame commit: if pending=1 at the frame_done cycle, shadow <= pending buffer, pending cleared, data_ready=1 from the next cycle.
  - A transfer accepted in the same cycle as frame_done lands in pending and is committed at the next frame, not this one.
- enable low in BLANK/DRIVE: next edge goes to IDLE, an off, idx 0, cnt 0, no frame_done. On IDLE entry any pending value is committed to shadow and data_ready returns to 1.
- data_valid without data_ready: ignored; the source must hold data_in.
- Async rst mid-frame: immediate return to reset values; the pending value is lost.

Test Plan:
(NUM_DIGITS=4, SCAN_DIV=10, BLANK_CYC=2, ACTIVE_LOW_AN=1)
1. Assert and release rst with enable=0 -> an=4'b1111, nibble_out=0, digit_idx=0, data_ready=1, frame_done=0; state holds IDLE for 20 cycles.
2. In IDLE, send 16'h4321 (valid & ready), then enable=1, digit_en=4'hF -> 2 cycles an=1111 then 8 cycles an=1110 with nibble 1; then 2 off + 8 cycles an=1101 with nibble 2, and so on; frame_done pulses once every 40 cycles at the last cycle of digit 3.
3. Running with 16'h4321, send 16'hABCD during digit 1 -> data_ready=0 next cycle; digits 2 and 3 still show 3 and 4; at frame_done the shadow is updated; the next frame shows D,C,B,A; data_ready=1 the cycle after frame_done.
4. digit_en=4'b0101 -> an stays 1111 throughout the digit 1 and digit 3 slots; digits 0 and 2 drive normally; frame period stays 40 cycles.
5. Drop enable mid-DRIVE of digit 2 with a pending value -> next edge an=1111, digit_idx=0, shadow updated, data_ready=1; re-enable -> scan restarts at digit 0 with a 2-cycle blank.
6. Assert rst asynchronously mid-DRIVE -> an=1111 and data_ready=1 before the next clk edge; after release, nibble_out=0 and the shadow reads 0.
